// File: rtl/serial_adder_sched_if.sv
// Request/result bundle for serial_adder_sched; SERIAL_ADDER_SUB_EN adds the subtract-select signals.
interface serial_adder_sched_if #(
  parameter int unsigned WIDTH = 8
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_sum;
  logic             res_carry;
  logic             res_id;
  logic             busy;
`ifdef SERIAL_ADDER_SUB_EN
  logic             req0_sub;
  logic             req1_sub;
  logic             res_sub;

  modport master (
    output req0_valid, req0_a, req0_b, req0_sub,
    output req1_valid, req1_a, req1_b, req1_sub,
    output res_ready,
    input  req0_ready, req1_ready, res_valid, res_sum, res_carry, res_id, res_sub, busy
  );
  modport slave (
    input  req0_valid, req0_a, req0_b, req0_sub,
    input  req1_valid, req1_a, req1_b, req1_sub,
    input  res_ready,
    output req0_ready, req1_ready, res_valid, res_sum, res_carry, res_id, res_sub, busy
  );
`else
  modport master (
    output req0_valid, req0_a, req0_b,
    output req1_valid, req1_a, req1_b,
    output res_ready,
    input  req0_ready, req1_ready, res_valid, res_sum, res_carry, res_id, busy
  );
  modport slave (
    input  req0_valid, req0_a, req0_b,
    input  req1_valid, req1_a, req1_b,
    input  res_ready,
    output req0_ready, req1_ready, res_valid, res_sum, res_carry, res_id, busy
  );
`endif
endinterface

// File: rtl/serial_adder_sched.sv
// Bit-serial adder shared by two round-robin arbitrated requesters, LSB first, one bit per clock.
// Define SERIAL_ADDER_SUB_EN to add per-request subtract (A-B via inverted B and carry-in 1).
module serial_adder_sched #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_adder_sched_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int unsigned   CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic             carry;
  logic [CW-1:0]    count;
  logic             id;
  logic             ptr;
  logic             grant0;
  logic             grant1;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic             sel_sub;
  logic             hs1_sum;
  logic             hs1_carry;
  logic             hs2_carry;
  logic             sum_bit;
  logic             carry_next;

  // Full-adder slice built from two half adders with the carries ORed.
  assign hs1_sum    = a_sr[0] ^ b_sr[0];
  assign hs1_carry  = a_sr[0] & b_sr[0];
  assign sum_bit    = hs1_sum ^ carry;
  assign hs2_carry  = hs1_sum & carry;
  assign carry_next = hs1_carry | hs2_carry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Grants are gated by rst_n so ready stays low while reset is held.
  always_comb begin
    state_next = state;
    grant0     = 1'b0;
    grant1     = 1'b0;
    case (state)
      IDLE: begin
        grant0 = rst_n & bus.req0_valid & (~ptr | ~bus.req1_valid);
        grant1 = rst_n & bus.req1_valid & ( ptr | ~bus.req0_valid);
        if (grant0 | grant1) state_next = RUN;
      end
      RUN:     if (count == LAST) state_next = DONE;
      DONE:    if (bus.res_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign sel_a = grant1 ? bus.req1_a : bus.req0_a;
  assign sel_b = grant1 ? bus.req1_b : bus.req0_b;

`ifdef SERIAL_ADDER_SUB_EN
  logic sub_q;
  assign sel_sub     = grant1 ? bus.req1_sub : bus.req0_sub;
  assign bus.res_sub = sub_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                sub_q <= 1'b0;
    else if (grant0 | grant1)  sub_q <= sel_sub;
  end
`else
  assign sel_sub = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      carry  <= 1'b0;
      count  <= '0;
      id     <= 1'b0;
      ptr    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0 | grant1) begin
            a_sr  <= sel_a;
            b_sr  <= sel_sub ? ~sel_b : sel_b;
            carry <= sel_sub;
            count <= '0;
            id    <= grant1;
            ptr   <= grant0;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          sum_sr <= {sum_bit, sum_sr[WIDTH-1:1]};
          carry  <= carry_next;
          count  <= count + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign bus.res_valid  = (state == DONE);
  assign bus.res_sum    = sum_sr;
  assign bus.res_carry  = carry;
  assign bus.res_id     = id;
  assign bus.busy       = (state != IDLE);
endmodule
